// File: rtl/sata_fifo_pkg.sv
// rtl/sata_fifo_pkg.sv - shared widths and defaults for the link-layer receive FIFO
package sata_fifo_pkg;
    localparam int FIFO_DATA_W = 36;
    localparam int FIFO_CNT_W  = 10;
    localparam int EOF_BIT     = 34;

    localparam int DEF_DEPTH               = 512;
    localparam int DEF_ALMOST_EMPTY_OFFSET = 256;
    localparam int DEF_ALMOST_FULL_OFFSET  = 128;

    typedef logic [FIFO_DATA_W-1:0] fifo_word_t;
    typedef logic [FIFO_CNT_W-1:0]  fifo_cnt_t;
endpackage

// File: rtl/sync_fifo36_fwft_if.sv
// rtl/sync_fifo36_fwft_if.sv - write/read side signals of the FWFT FIFO
interface sync_fifo36_fwft_if;
    import sata_fifo_pkg::*;

    fifo_word_t wr_di;
    logic       wr_en;
    logic       wr_full;
    logic       wr_almost_full;
    fifo_cnt_t  wr_count;
    logic       wr_err;
    logic       rd_en;
    fifo_word_t rd_do;
    logic       rd_empty;
    logic       rd_almost_empty;
    fifo_cnt_t  rd_count;
    logic       rd_err;

    modport master (
        output wr_di, wr_en, rd_en,
        input  wr_full, wr_almost_full, wr_count, wr_err,
        input  rd_do, rd_empty, rd_almost_empty, rd_count, rd_err
    );

    modport slave (
        input  wr_di, wr_en, rd_en,
        output wr_full, wr_almost_full, wr_count, wr_err,
        output rd_do, rd_empty, rd_almost_empty, rd_count, rd_err
    );
endinterface

// File: rtl/sync_fifo36_fwft_ram.sv
// rtl/sync_fifo36_fwft_ram.sv - simple dual-port storage, registered read port with enable
module sync_fifo_ram
    import sata_fifo_pkg::*;
#(
    parameter int C_DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(C_DEPTH)-1:0] wr_addr,
    input  fifo_word_t                 wr_data,
    input  logic                       rd_en,
    input  logic [$clog2(C_DEPTH)-1:0] rd_addr,
    output fifo_word_t                 rd_data
);
    fifo_word_t mem [C_DEPTH];

    // rd_data holds while rd_en is low; the top relies on that to keep the head word stable
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/sync_fifo36_fwft.sv
// rtl/sync_fifo36_fwft.sv - single-clock first-word-fall-through FIFO with count and error strobes
module sync_fifo36_fwft
    import sata_fifo_pkg::*;
#(
    parameter int C_DEPTH               = DEF_DEPTH,
    parameter int C_ALMOST_EMPTY_OFFSET = DEF_ALMOST_EMPTY_OFFSET,
    parameter int C_ALMOST_FULL_OFFSET  = DEF_ALMOST_FULL_OFFSET
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo36_fwft_if.slave  fifo
);
    localparam int        AW       = $clog2(C_DEPTH);
    localparam fifo_cnt_t DEPTH_CNT = fifo_cnt_t'(C_DEPTH);
    localparam fifo_cnt_t AE_CNT    = fifo_cnt_t'(C_ALMOST_EMPTY_OFFSET);
    localparam fifo_cnt_t AF_CNT    = fifo_cnt_t'(C_DEPTH - C_ALMOST_FULL_OFFSET);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    fifo_cnt_t     count;
    fifo_cnt_t     count_nxt;
    logic          wr_acc;
    logic          rd_acc;
    logic          ram_re;
    logic          byp_ld;
    fifo_word_t    ram_q;
    fifo_word_t    byp_q;
    logic          out_sel_ram;
    logic          full_q;
    logic          empty_q;
    logic          almost_empty_q;
    logic          almost_full_q;
    logic          wr_err_q;
    logic          rd_err_q;

    // The head word lives either in the bypass register (it arrived while the FIFO
    // held at most one word) or in the RAM read register (prefetched on a pop).
    always_comb begin
        wr_acc    = fifo.wr_en && !full_q;
        rd_acc    = fifo.rd_en && !empty_q;
        count_nxt = count;
        if (wr_acc && !rd_acc)
            count_nxt = count + fifo_cnt_t'(1);
        else if (rd_acc && !wr_acc)
            count_nxt = count - fifo_cnt_t'(1);
        ram_re = rd_acc && (count > fifo_cnt_t'(1));
        byp_ld = wr_acc && ((count == '0) || ((count == fifo_cnt_t'(1)) && rd_acc));
    end

    sync_fifo_ram #(.C_DEPTH(C_DEPTH)) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (fifo.wr_di),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr + AW'(1)),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
            wr_err_q       <= 1'b0;
            rd_err_q       <= 1'b0;
            byp_q          <= '0;
            out_sel_ram    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            count          <= count_nxt;
            full_q         <= (count_nxt == DEPTH_CNT);
            empty_q        <= (count_nxt == '0);
            almost_empty_q <= (count_nxt <= AE_CNT);
            almost_full_q  <= (count_nxt >= AF_CNT);
            wr_err_q       <= fifo.wr_en && full_q;
            rd_err_q       <= fifo.rd_en && empty_q;
            if (byp_ld) begin
                byp_q       <= fifo.wr_di;
                out_sel_ram <= 1'b0;
            end else if (ram_re) begin
                out_sel_ram <= 1'b1;
            end
        end
    end

    assign fifo.rd_do           = out_sel_ram ? ram_q : byp_q;
    assign fifo.rd_empty        = empty_q;
    assign fifo.rd_almost_empty = almost_empty_q;
    assign fifo.rd_count        = count;
    assign fifo.rd_err          = rd_err_q;
    assign fifo.wr_full         = full_q;
    assign fifo.wr_almost_full  = almost_full_q;
    assign fifo.wr_count        = count;
    assign fifo.wr_err          = wr_err_q;
endmodule

// File: tb/tb_sync_fifo36_fwft.sv
// tb/tb_sync_fifo36_fwft.sv - randomized self-checking bench for sync_fifo36_fwft
module tb_sync_fifo36_fwft;
    localparam int DEPTH = 512;
    localparam int AE    = 256;
    localparam int AF    = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [35:0] mq[$];
    logic        m_werr = 1'b0;
    logic        m_rerr = 1'b0;

    sync_fifo36_fwft_if bus ();

    sync_fifo36_fwft #(
        .C_DEPTH               (DEPTH),
        .C_ALMOST_EMPTY_OFFSET (AE),
        .C_ALMOST_FULL_OFFSET  (AF)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] rand_word();
        return {4'($urandom_range(0, 15)), 32'($urandom)};
    endfunction

    // One clock: drive, let the edge happen, update the queue model, sample at +1.
    task automatic cyc(input logic we, input logic [35:0] d, input logic re);
        bit can_w;
        bit can_r;
        bus.wr_en = we;
        bus.wr_di = d;
        bus.rd_en = re;
        @(posedge clk);
        can_w  = (mq.size() < DEPTH);
        can_r  = (mq.size() > 0);
        m_werr = we && !can_w;
        m_rerr = re && !can_r;
        if (re && can_r) void'(mq.pop_front());
        if (we && can_w) mq.push_back(d);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.wr_di = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_werr = 1'b0;
        m_rerr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.rd_do !== 36'h0) begin bad++; $display("FAIL reset_rd_do got=%h exp=0", bus.rd_do); end
        cyc(1'b0, '0, 1'b0);
        total++; if (bus.rd_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.rd_empty); end
        total++; if (bus.rd_almost_empty !== 1'b1) begin bad++; $display("FAIL reset_aempty got=%b exp=1", bus.rd_almost_empty); end
        total++; if (bus.wr_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.wr_full); end
        total++; if (bus.wr_almost_full !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b exp=0", bus.wr_almost_full); end
        total++; if (bus.wr_count !== 10'd0 || bus.rd_count !== 10'd0) begin bad++; $display("FAIL reset_count got=%0d/%0d exp=0", bus.wr_count, bus.rd_count); end
        total++; if (bus.wr_err !== 1'b0 || bus.rd_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", bus.wr_err, bus.rd_err); end
    endtask

    task automatic test_basic();
        cyc(1'b1, 36'h0_0000_0001, 1'b0);
        total++; if (bus.rd_empty !== 1'b0) begin bad++; $display("FAIL basic_nonempty got=%b exp=0", bus.rd_empty); end
        total++; if (bus.rd_do !== 36'h0_0000_0001) begin bad++; $display("FAIL basic_first got=%h exp=000000001", bus.rd_do); end
        total++; if (bus.rd_count !== 10'd1) begin bad++; $display("FAIL basic_count1 got=%0d exp=1", bus.rd_count); end
        cyc(1'b1, 36'h4_DEAD_BEEF, 1'b0);
        total++; if (bus.rd_do !== 36'h0_0000_0001) begin bad++; $display("FAIL basic_hold got=%h exp=000000001", bus.rd_do); end
        cyc(1'b0, '0, 1'b1);
        total++; if (bus.rd_do !== 36'h4_DEAD_BEEF) begin bad++; $display("FAIL basic_second got=%h exp=4deadbeef", bus.rd_do); end
        cyc(1'b0, '0, 1'b1);
        total++; if (bus.rd_empty !== 1'b1 || bus.rd_count !== 10'd0) begin bad++; $display("FAIL basic_drained got=%b/%0d exp=1/0", bus.rd_empty, bus.rd_count); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1'b1, rand_word(), 1'b0);
            total++; if (bus.wr_count !== 10'(i)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", bus.wr_count, i); end
            total++; if (bus.rd_almost_empty !== (i <= AE)) begin bad++; $display("FAIL fill_aempty at=%0d got=%b exp=%b", i, bus.rd_almost_empty, i <= AE); end
            total++; if (bus.wr_almost_full !== (i >= DEPTH - AF)) begin bad++; $display("FAIL fill_afull at=%0d got=%b exp=%b", i, bus.wr_almost_full, i >= DEPTH - AF); end
            total++; if (bus.wr_full !== (i == DEPTH)) begin bad++; $display("FAIL fill_full at=%0d got=%b exp=%b", i, bus.wr_full, i == DEPTH); end
            total++; if (bus.rd_do !== mq[0]) begin bad++; $display("FAIL fill_head at=%0d got=%h exp=%h", i, bus.rd_do, mq[0]); end
        end
    endtask

    task automatic test_overflow_drain();
        cyc(1'b1, rand_word(), 1'b0);
        total++; if (bus.wr_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", bus.wr_err); end
        total++; if (bus.wr_count !== 10'd512) begin bad++; $display("FAIL ovf_count got=%0d exp=512", bus.wr_count); end
        cyc(1'b0, '0, 1'b0);
        total++; if (bus.wr_err !== 1'b0) begin bad++; $display("FAIL ovf_err_pulse got=%b exp=0", bus.wr_err); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (bus.rd_do !== mq[0]) begin bad++; $display("FAIL drain_data idx=%0d got=%h exp=%h", i, bus.rd_do, mq[0]); end
            cyc(1'b0, '0, 1'b1);
        end
        total++; if (bus.rd_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", bus.rd_empty); end
        cyc(1'b0, '0, 1'b1);
        total++; if (bus.rd_err !== 1'b1) begin bad++; $display("FAIL udf_err got=%b exp=1", bus.rd_err); end
        total++; if (bus.rd_count !== 10'd0) begin bad++; $display("FAIL udf_count got=%0d exp=0", bus.rd_count); end
        cyc(1'b0, '0, 1'b0);
        total++; if (bus.rd_err !== 1'b0) begin bad++; $display("FAIL udf_err_pulse got=%b exp=0", bus.rd_err); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) cyc(1'b1, rand_word(), 1'b0);
        for (int i = 0; i < 1000; i++) begin
            cyc(1'b1, rand_word(), 1'b1);
            total++; if (bus.rd_count !== 10'd5) begin bad++; $display("FAIL b2b_count cyc=%0d got=%0d exp=5", i, bus.rd_count); end
            total++; if (bus.rd_do !== mq[0]) begin bad++; $display("FAIL b2b_head cyc=%0d got=%h exp=%h", i, bus.rd_do, mq[0]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 100; i++) cyc(1'b1, rand_word(), 1'b0);
        total++; if (bus.rd_count !== 10'd100) begin bad++; $display("FAIL mid_pre_count got=%0d exp=100", bus.rd_count); end
        do_reset();
        total++; if (bus.rd_count !== 10'd0 || bus.rd_empty !== 1'b1) begin bad++; $display("FAIL mid_reset got=%0d/%b exp=0/1", bus.rd_count, bus.rd_empty); end
        cyc(1'b1, 36'h1_2345_6789, 1'b0);
        cyc(1'b1, 36'hA_0000_00A5, 1'b0);
        total++; if (bus.rd_do !== 36'h1_2345_6789) begin bad++; $display("FAIL mid_first got=%h exp=123456789", bus.rd_do); end
        cyc(1'b0, '0, 1'b1);
        total++; if (bus.rd_do !== 36'hA_0000_00A5) begin bad++; $display("FAIL mid_second got=%h exp=a000000a5", bus.rd_do); end
    endtask

    task automatic test_random();
        int wr_pct;
        for (int i = 0; i < 3000; i++) begin
            wr_pct = ((i / 500) % 2 == 0) ? 75 : 25;
            cyc($urandom_range(0, 99) < wr_pct, rand_word(), $urandom_range(0, 99) < (100 - wr_pct));
            total++; if (bus.wr_count !== 10'(mq.size())) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, bus.wr_count, mq.size()); end
            total++; if (bus.rd_empty !== (mq.size() == 0) || bus.wr_full !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rnd_flags cyc=%0d got=%b%b", i, bus.rd_empty, bus.wr_full); end
            total++; if (bus.wr_err !== m_werr || bus.rd_err !== m_rerr) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b%b exp=%b%b", i, bus.wr_err, bus.rd_err, m_werr, m_rerr); end
            if (mq.size() != 0) begin
                total++; if (bus.rd_do !== mq[0]) begin bad++; $display("FAIL rnd_head cyc=%0d got=%h exp=%h", i, bus.rd_do, mq[0]); end
            end
        end
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.wr_di = '0;
        test_reset();
        test_basic();
        test_fill();
        test_overflow_drain();
        test_back_to_back();
        test_reset_mid();
        do_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
